ntt_bfly_pipe: RTL and testbench

Parametrised, fully pipelined NTT butterfly for the Dilithium PQC accelerator. It supports forward Cooley-Tukey (CT) and inverse Gentleman-Sande (GS) butterflies, selected per transaction. Modular reduction is true Barrett rather than a `%` operator. Each transaction carries a tag through the pipe, and the block uses valid/ready flow control. It sits between the coefficient RAM read port and the write-back path of the polynomial multiplier.

---
 rtl/ntt_pkg.sv | 48 ++++
 rtl/barrett_reduce.sv | 43 ++++
 rtl/ntt_bfly_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_ntt_bfly_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, Barrett factor and modular add/sub helpers for the NTT datapath
package ntt_pkg;

   // Default coefficient width and modulus (Dilithium).
   localparam int unsigned NTT_W = 23;
   localparam int unsigned NTT_Q = 8380417;

   // Width the modular helpers operate in; coefficients up to 31 bits fit
   // without the add/subtract intermediates overflowing.
   localparam int unsigned ARITH_W = 32;

   // Butterfly mode encoding.
   localparam logic MODE_CT = 1'b0;
   localparam logic MODE_GS = 1'b1;

   // Barrett factor floor(2^(2w) / q); fits in w+1 bits because q > 2^(w-1).
   function automatic longint unsigned barrett_mu(input int unsigned w, input int unsigned q);
      return (64'd1 << (2 * w)) / 64'(q);
   endfunction

   localparam longint unsigned NTT_MU = barrett_mu(NTT_W, NTT_Q);

   // (a + b) mod q for a, b in [0, q): a single conditional subtract suffices.
   function automatic logic [ARITH_W-1:0] mod_add(input logic [ARITH_W-1:0] a,
                                                  input logic [ARITH_W-1:0] b,
                                                  input logic [ARITH_W-1:0] q);
      logic [ARITH_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) begin
         s = s - {1'b0, q};
      end
      return s[ARITH_W-1:0];
   endfunction

   // (a - b) mod q for a, b in [0, q): add q back when the difference goes negative.
   function automatic logic [ARITH_W-1:0] mod_sub(input logic [ARITH_W-1:0] a,
                                                  input logic [ARITH_W-1:0] b,
                                                  input logic [ARITH_W-1:0] q);
      logic [ARITH_W-1:0] d;
      if (a >= b) begin
         d = a - b;
      end else begin
         d = (a + q) - b;
      end
      return d;
   endfunction

endpackage

// File: rtl/barrett_reduce.sv
// rtl/barrett_reduce.sv - combinational Barrett reduction of a 2W-bit product to [0, Q)
// Ports:
//   p  input  2W bits : value to reduce, p < 2^(2W)
//   r  output W bits  : p mod Q
module barrett_reduce
   import ntt_pkg::*;
#(
   parameter int unsigned W = NTT_W,
   parameter int unsigned Q = NTT_Q
) (
   input  logic [2*W-1:0] p,
   output logic [W-1:0]   r
);

   localparam int unsigned PW   = 3 * W + 1;
   localparam int unsigned QH_W = W + 1;
   localparam int unsigned QQ_W = 2 * W + 1;
   localparam int unsigned R_W  = W + 2;

   localparam logic [QH_W-1:0] MU  = QH_W'(barrett_mu(W, Q));
   localparam logic [QQ_W-1:0] Q_X = QQ_W'(Q);
   localparam logic [R_W-1:0]  Q_R = R_W'(Q);

   logic [PW-1:0]   prod;
   logic [QH_W-1:0] qh;
   logic [QQ_W-1:0] qhq;
   logic [R_W-1:0]  r0;
   logic [R_W-1:0]  r1;
   logic [R_W-1:0]  r2;

   always_comb begin
      prod = {{(W + 1){1'b0}}, p} * {{(2 * W){1'b0}}, MU};
      qh   = QH_W'(prod >> (2 * W));
      qhq  = {{W{1'b0}}, qh} * Q_X;
      // The quotient estimate undershoots by at most 2, so the true remainder
      // is below 3Q and the low W+2 bits of the difference are exact.
      r0   = R_W'(p) - R_W'(qhq);
      r1   = (r0 >= Q_R) ? (r0 - Q_R) : r0;
      r2   = (r1 >= Q_R) ? (r1 - Q_R) : r1;
      r    = W'(r2);
   end

endmodule

// File: rtl/ntt_bfly_pipe.sv
// rtl/ntt_bfly_pipe.sv - four-stage pipelined CT/GS NTT butterfly with tag sideband and valid/ready flow
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   input handshake; in_ready = ~stall
//   in_mode              0 = Cooley-Tukey, 1 = Gentleman-Sande
//   in_a, in_b, in_zeta  operands, expected in [0, Q)
//   in_tag               sideband returned unchanged with the result
//   out_valid, out_ready output handshake
//   out_u, out_v         butterfly results in [0, Q)
//   out_tag              tag of the transaction
//   out_err              an operand was >= Q; out_u/out_v forced to zero
module ntt_bfly_pipe
   import ntt_pkg::*;
#(
   parameter int unsigned W     = NTT_W,
   parameter int unsigned Q     = NTT_Q,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W-1:0]     in_zeta,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_u,
   output logic [W-1:0]     out_v,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam logic [W-1:0] Q_W = W'(Q);

   // S1: pre-add. x carries a (CT) or a+b (GS) to the post-add stage,
   // m is the multiplier operand: b (CT) or a-b (GS).
   logic             v1_q, v1_d;
   logic [W-1:0]     x1_q, x1_d;
   logic [W-1:0]     m1_q, m1_d;
   logic [W-1:0]     z1_q, z1_d;
   logic             mode1_q, mode1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d;
   logic             err1_q, err1_d;

   // S2: multiply.
   logic             v2_q, v2_d;
   logic [W-1:0]     x2_q, x2_d;
   logic [2*W-1:0]   p2_q, p2_d;
   logic             mode2_q, mode2_d;
   logic [TAG_W-1:0] tag2_q, tag2_d;
   logic             err2_q, err2_d;

   // S3: Barrett reduction.
   logic             v3_q, v3_d;
   logic [W-1:0]     x3_q, x3_d;
   logic [W-1:0]     r3_q, r3_d;
   logic             mode3_q, mode3_d;
   logic [TAG_W-1:0] tag3_q, tag3_d;
   logic             err3_q, err3_d;

   // S4: post-add, drives the outputs directly.
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_u_q, out_u_d;
   logic [W-1:0]     out_v_q, out_v_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_err_q, out_err_d;

   logic             stall;
   logic             advance;
   logic [W-1:0]     r_red;

   barrett_reduce #(
      .W (W),
      .Q (Q)
   ) u_barrett (
      .p (p2_q),
      .r (r_red)
   );

   // A full output slot that is not being drained freezes the whole pipe;
   // bubbles are never squeezed out, so a single enable covers every stage.
   assign stall     = out_valid_q & ~out_ready;
   assign advance   = ~stall;
   assign in_ready  = advance;

   assign out_valid = out_valid_q;
   assign out_u     = out_u_q;
   assign out_v     = out_v_q;
   assign out_tag   = out_tag_q;
   assign out_err   = out_err_q;

   always_comb begin
      v1_d        = v1_q;
      x1_d        = x1_q;
      m1_d        = m1_q;
      z1_d        = z1_q;
      mode1_d     = mode1_q;
      tag1_d      = tag1_q;
      err1_d      = err1_q;
      v2_d        = v2_q;
      x2_d        = x2_q;
      p2_d        = p2_q;
      mode2_d     = mode2_q;
      tag2_d      = tag2_q;
      err2_d      = err2_q;
      v3_d        = v3_q;
      x3_d        = x3_q;
      r3_d        = r3_q;
      mode3_d     = mode3_q;
      tag3_d      = tag3_q;
      err3_d      = err3_q;
      out_valid_d = out_valid_q;
      out_u_d     = out_u_q;
      out_v_d     = out_v_q;
      out_tag_d   = out_tag_q;
      out_err_d   = out_err_q;

      if (advance) begin
         // S1
         v1_d    = in_valid;
         z1_d    = in_zeta;
         mode1_d = in_mode;
         tag1_d  = in_tag;
         err1_d  = (in_a >= Q_W) | (in_b >= Q_W) | (in_zeta >= Q_W);
         if (in_mode == MODE_GS) begin
            x1_d = W'(mod_add(ARITH_W'(in_a), ARITH_W'(in_b), Q));
            m1_d = W'(mod_sub(ARITH_W'(in_a), ARITH_W'(in_b), Q));
         end else begin
            x1_d = in_a;
            m1_d = in_b;
         end

         // S2
         v2_d    = v1_q;
         x2_d    = x1_q;
         p2_d    = {{W{1'b0}}, m1_q} * {{W{1'b0}}, z1_q};
         mode2_d = mode1_q;
         tag2_d  = tag1_q;
         err2_d  = err1_q;

         // S3
         v3_d    = v2_q;
         x3_d    = x2_q;
         r3_d    = r_red;
         mode3_d = mode2_q;
         tag3_d  = tag2_q;
         err3_d  = err2_q;

         // S4: an errored transaction keeps its slot and tag but carries zeros.
         out_valid_d = v3_q;
         out_tag_d   = tag3_q;
         out_err_d   = err3_q;
         if (err3_q) begin
            out_u_d = '0;
            out_v_d = '0;
         end else if (mode3_q == MODE_GS) begin
            out_u_d = x3_q;
            out_v_d = r3_q;
         end else begin
            out_u_d = W'(mod_add(ARITH_W'(x3_q), ARITH_W'(r3_q), Q));
            out_v_d = W'(mod_sub(ARITH_W'(x3_q), ARITH_W'(r3_q), Q));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         x1_q        <= '0;
         m1_q        <= '0;
         z1_q        <= '0;
         mode1_q     <= MODE_CT;
         tag1_q      <= '0;
         err1_q      <= 1'b0;
         v2_q        <= 1'b0;
         x2_q        <= '0;
         p2_q        <= '0;
         mode2_q     <= MODE_CT;
         tag2_q      <= '0;
         err2_q      <= 1'b0;
         v3_q        <= 1'b0;
         x3_q        <= '0;
         r3_q        <= '0;
         mode3_q     <= MODE_CT;
         tag3_q      <= '0;
         err3_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_u_q     <= '0;
         out_v_q     <= '0;
         out_tag_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         x1_q        <= x1_d;
         m1_q        <= m1_d;
         z1_q        <= z1_d;
         mode1_q     <= mode1_d;
         tag1_q      <= tag1_d;
         err1_q      <= err1_d;
         v2_q        <= v2_d;
         x2_q        <= x2_d;
         p2_q        <= p2_d;
         mode2_q     <= mode2_d;
         tag2_q      <= tag2_d;
         err2_q      <= err2_d;
         v3_q        <= v3_d;
         x3_q        <= x3_d;
         r3_q        <= r3_d;
         mode3_q     <= mode3_d;
         tag3_q      <= tag3_d;
         err3_q      <= err3_d;
         out_valid_q <= out_valid_d;
         out_u_q     <= out_u_d;
         out_v_q     <= out_v_d;
         out_tag_q   <= out_tag_d;
         out_err_q   <= out_err_d;
      end
   end

endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// tb/tb_ntt_bfly_pipe.sv - scoreboard bench for ntt_bfly_pipe
module tb_ntt_bfly_pipe;
   import ntt_pkg::*;

   localparam int unsigned W     = 23;
   localparam int unsigned Q     = 8380417;
   localparam int unsigned TAG_W = 8;

   typedef struct packed {
      logic [W-1:0]     u;
      logic [W-1:0]     v;
      logic [TAG_W-1:0] tag;
      logic             err;
   } res_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [W-1:0]     in_zeta;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_u;
   logic [W-1:0]     out_v;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   res_t sb[$];
   res_t cur;
   res_t want;
   int   n_cmp = 0;
   int   n_bad = 0;

   ntt_bfly_pipe #(.W(W), .Q(Q), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_zeta   (in_zeta),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_u     (out_u),
      .out_v     (out_v),
      .out_tag   (out_tag),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign cur = {out_u, out_v, out_tag, out_err};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   function automatic res_t model(input logic m, input longint unsigned a, input longint unsigned b,
                                  input longint unsigned z, input logic [TAG_W-1:0] t);
      longint unsigned qq = 64'(Q);
      longint unsigned u, v, bz, d;
      res_t r;
      r.err = (a >= qq) || (b >= qq) || (z >= qq);
      if (r.err) begin
         u = 0;
         v = 0;
      end else if (m == MODE_CT) begin
         bz = (b * z) % qq;
         u  = (a + bz) % qq;
         v  = (a + qq - bz) % qq;
      end else begin
         d = (a + qq - b) % qq;
         u = (a + b) % qq;
         v = (d * z) % qq;
      end
      r.u   = W'(u);
      r.v   = W'(v);
      r.tag = t;
      return r;
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic send(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] z, input logic [TAG_W-1:0] t);
      logic took;
      in_valid = 1'b1;
      in_mode  = m;
      in_a     = a;
      in_b     = b;
      in_zeta  = z;
      in_tag   = t;
      took     = 1'b0;
      for (int i = 0; i < 64 && !took; i++) begin
         #1;
         took = in_ready;
         @(negedge clk);
      end
      if (!took) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_accept: tag %h in_ready stayed 0, want 1", t);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = MODE_CT;
      in_a      = '0;
      in_b      = '0;
      in_zeta   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid: got out_valid=%b, want 0", out_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || cur !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid=%b u=%0d v=%0d tag=%h err=%b, want all 0",
                  out_valid, out_u, out_v, out_tag, out_err);
      end
   endtask

   task automatic test_ct_latency();
      sb.push_back('{u: 23'd7, v: 23'd8380412, tag: 8'h5A, err: 1'b0});
      send(MODE_CT, 23'd1, 23'd2, 23'd3, 8'h5A);
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ct_latency_early: out_valid=%b at cycle %0d, want 0", out_valid, c);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL ct_latency: out_valid=%b at cycle 4, want 1", out_valid);
      end
      want = sb.pop_front();
      n_cmp++;
      if (cur !== want) begin
         n_bad++;
         $display("FAIL ct_result: got u=%0d v=%0d tag=%h err=%b, want u=%0d v=%0d tag=%h err=%b",
                  cur.u, cur.v, cur.tag, cur.err, want.u, want.v, want.tag, want.err);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ct_single: out_valid=%b after drain, want 0", out_valid);
      end
   endtask

   task automatic test_gs();
      int got = 0;
      sb.push_back('{u: 23'd8, v: 23'd4, tag: 8'h11, err: 1'b0});
      sb.push_back('{u: 23'd8, v: 23'd8380415, tag: 8'h12, err: 1'b0});
      send(MODE_GS, 23'd5, 23'd3, 23'd2, 8'h11);
      send(MODE_GS, 23'd3, 23'd5, 23'd1, 8'h12);
      in_valid = 1'b0;
      for (int c = 0; c < 40 && got < 2; c++) begin
         @(negedge clk);
         if (out_valid) begin
            want = sb.pop_front();
            n_cmp++;
            if (cur !== want) begin
               n_bad++;
               $display("FAIL gs_result: got u=%0d v=%0d tag=%h err=%b, want u=%0d v=%0d tag=%h err=%b",
                        cur.u, cur.v, cur.tag, cur.err, want.u, want.v, want.tag, want.err);
            end
            got++;
         end
      end
      n_cmp++;
      if (got != 2) begin
         n_bad++;
         $display("FAIL gs_count: got %0d outputs, want 2", got);
      end
   endtask

   task automatic test_boundary();
      int got = 0;
      logic [W-1:0] qm1;
      qm1 = W'(Q - 1);
      sb.push_back('{u: 23'd0, v: 23'd8380415, tag: 8'h21, err: 1'b0});
      sb.push_back('{u: 23'd8380415, v: 23'd0, tag: 8'h22, err: 1'b0});
      send(MODE_CT, qm1, qm1, qm1, 8'h21);
      send(MODE_GS, qm1, qm1, qm1, 8'h22);
      in_valid = 1'b0;
      for (int c = 0; c < 40 && got < 2; c++) begin
         @(negedge clk);
         if (out_valid) begin
            want = sb.pop_front();
            n_cmp++;
            if (cur !== want) begin
               n_bad++;
               $display("FAIL boundary_result: got u=%0d v=%0d tag=%h err=%b, want u=%0d v=%0d tag=%h err=%b",
                        cur.u, cur.v, cur.tag, cur.err, want.u, want.v, want.tag, want.err);
            end
            got++;
         end
      end
      n_cmp++;
      if (got != 2) begin
         n_bad++;
         $display("FAIL boundary_count: got %0d outputs, want 2", got);
      end
   endtask

   task automatic test_err();
      int got = 0;
      sb.push_back('{u: 23'd0, v: 23'd0, tag: 8'h33, err: 1'b1});
      sb.push_back('{u: 23'd610, v: 23'd8379827, tag: 8'h34, err: 1'b0});
      send(MODE_CT, W'(Q), 23'd1, 23'd1, 8'h33);
      send(MODE_CT, 23'd10, 23'd20, 23'd30, 8'h34);
      in_valid = 1'b0;
      for (int c = 0; c < 40 && got < 2; c++) begin
         @(negedge clk);
         if (out_valid) begin
            want = sb.pop_front();
            n_cmp++;
            if (cur !== want) begin
               n_bad++;
               $display("FAIL err_result: got u=%0d v=%0d tag=%h err=%b, want u=%0d v=%0d tag=%h err=%b",
                        cur.u, cur.v, cur.tag, cur.err, want.u, want.v, want.tag, want.err);
            end
            got++;
         end
      end
      n_cmp++;
      if (got != 2) begin
         n_bad++;
         $display("FAIL err_count: got %0d outputs, want 2", got);
      end
   endtask

   task automatic test_back_to_back();
      fork
         begin : drive
            logic [W-1:0] a, b, z;
            logic         m;
            for (int i = 0; i < 16; i++) begin
               m = (i % 2 == 1) ? MODE_GS : MODE_CT;
               a = (i == 2) ? W'(Q - 1) : W'($urandom_range(Q - 1, 0));
               b = (i == 3) ? W'(Q - 1) : W'($urandom_range(Q - 1, 0));
               z = W'($urandom_range(Q - 1, 0));
               sb.push_back(model(m, 64'(a), 64'(b), 64'(z), TAG_W'(8'h80 + i)));
               send(m, a, b, z, TAG_W'(8'h80 + i));
            end
            in_valid = 1'b0;
         end
         begin : drain
            int got  = 0;
            int hold = 0;
            bit held = 1'b0;
            for (int c = 0; c < 300 && got < 16; c++) begin
               @(negedge clk);
               if (hold > 0) begin
                  n_cmp++;
                  if (out_valid !== 1'b1 || cur !== sb[0]) begin
                     n_bad++;
                     $display("FAIL b2b_frozen: got valid=%b u=%0d v=%0d tag=%h, want valid=1 u=%0d v=%0d tag=%h",
                              out_valid, cur.u, cur.v, cur.tag, sb[0].u, sb[0].v, sb[0].tag);
                  end
                  n_cmp++;
                  if (in_ready !== 1'b0) begin
                     n_bad++;
                     $display("FAIL b2b_in_ready: got %b during stall, want 0", in_ready);
                  end
                  hold--;
                  if (hold > 0) continue;
                  out_ready = 1'b1;
               end
               if (out_valid) begin
                  if (got == 5 && !held) begin
                     held      = 1'b1;
                     hold      = 3;
                     out_ready = 1'b0;
                     continue;
                  end
                  want = sb.pop_front();
                  n_cmp++;
                  if (cur !== want) begin
                     n_bad++;
                     $display("FAIL b2b_result: got u=%0d v=%0d tag=%h err=%b, want u=%0d v=%0d tag=%h err=%b",
                              cur.u, cur.v, cur.tag, cur.err, want.u, want.v, want.tag, want.err);
                  end
                  got++;
               end
            end
            n_cmp++;
            if (got != 16 || sb.size() != 0) begin
               n_bad++;
               $display("FAIL b2b_count: got %0d outputs with %0d left expected, want 16 and 0", got, sb.size());
            end
         end
      join
      out_ready = 1'b1;
   endtask

   task automatic test_reset_midflight();
      sb.delete();
      send(MODE_CT, 23'd4, 23'd5, 23'd6, 8'h60);
      send(MODE_GS, 23'd7, 23'd8, 23'd9, 8'h61);
      send(MODE_CT, 23'd1, 23'd1, 23'd1, 8'h62);
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_before: out_valid=%b with work in flight, want 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || cur !== '0) begin
         n_bad++;
         $display("FAIL midrst_async: got valid=%b u=%0d v=%0d tag=%h err=%b, want all 0",
                  out_valid, out_u, out_v, out_tag, out_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_stale: out_valid=%b at cycle %0d after release, want 0", out_valid, c);
         end
      end
      sb.push_back('{u: 23'd8, v: 23'd4, tag: 8'h77, err: 1'b0});
      send(MODE_GS, 23'd5, 23'd3, 23'd2, 8'h77);
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_latency_early: out_valid=%b at cycle %0d, want 0", out_valid, c);
         end
         @(negedge clk);
      end
      want = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || cur !== want) begin
         n_bad++;
         $display("FAIL midrst_result: got valid=%b u=%0d v=%0d tag=%h err=%b, want valid=1 u=%0d v=%0d tag=%h err=%b",
                  out_valid, cur.u, cur.v, cur.tag, cur.err, want.u, want.v, want.tag, want.err);
      end
   endtask

   initial begin
      test_reset();
      test_ct_latency();
      test_gs();
      test_boundary();
      test_err();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
